// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXIS packet arbiter.
// Holds the FSM state encoding and the packet counter width.
package axis_arb_pkg;

  localparam int PKT_CNT_W = 16;
  localparam logic [PKT_CNT_W-1:0] PKT_CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle for the packet arbiter.
// N slave-side streams in, one master-side stream out.
interface axis_packet_arbiter_if #(
  parameter int NUM_PORTS      = 4,
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1
);

  logic [NUM_PORTS-1:0] axis_i_tvalid;
  logic [NUM_PORTS-1:0] axis_i_tready;
  logic [NUM_PORTS-1:0] axis_i_tlast;
  logic [NUM_PORTS-1:0] axis_i_error;
  logic [NUM_PORTS*AXIS_BYTES*8-1:0] axis_i_tdata;
  logic [NUM_PORTS*AXIS_USER_BITS-1:0] axis_i_tuser;

  logic axis_o_tvalid;
  logic axis_o_tready;
  logic axis_o_tlast;
  logic axis_o_drop;
  logic [AXIS_BYTES*8-1:0] axis_o_tdata;
  logic [AXIS_USER_BITS-1:0] axis_o_tuser;

  modport slave (
    input  axis_i_tvalid, axis_i_tlast, axis_i_error,
    input  axis_i_tdata, axis_i_tuser,
    output axis_i_tready,
    output axis_o_tvalid, axis_o_tlast, axis_o_drop,
    output axis_o_tdata, axis_o_tuser,
    input  axis_o_tready
  );

  modport master (
    output axis_i_tvalid, axis_i_tlast, axis_i_error,
    output axis_i_tdata, axis_i_tuser,
    input  axis_i_tready,
    input  axis_o_tvalid, axis_o_tlast, axis_o_drop,
    input  axis_o_tdata, axis_o_tuser,
    output axis_o_tready
  );

endinterface

// File: rtl/rr_priority_select.sv
// Round-robin pick: first requester at or after ptr, wrapping.
// Purely combinational; returns one-hot grant and its index.
module rr_priority_select #(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  function automatic logic [IDX_W-1:0] wrap_idx(
    input logic [IDX_W-1:0] p,
    input int off
  );
    int s;
    s = int'(p) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_W'(s);
  endfunction

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = wrap_idx(ptr, i);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin AXIS arbiter, N streams to one.
// Grant is held from arbitration until the tlast handshake.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_PORTS      = 4
) (
  input  logic                 clk,
  input  logic                 aresetn,
  axis_packet_arbiter_if.slave axis,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PKT_CNT_W-1:0] o_pkt_count
);

  localparam int DW = AXIS_BYTES * 8;
  localparam int UW = AXIS_USER_BITS;
  localparam int IW = $clog2(NUM_PORTS);

  arb_state_e state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] ptr_nxt;
  logic [NUM_PORTS-1:0] sel_gnt;
  logic sel_any;
  logic pass;
  logic last_hs;

  rr_priority_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_sel (
    .req (axis.axis_i_tvalid),
    .ptr (ptr),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

  assign pass = (state == PASS);

  // Data path is a pure mux on the registered owner index.
  assign axis.axis_o_tvalid = pass & axis.axis_i_tvalid[gidx];
  assign axis.axis_o_tlast  = pass & axis.axis_i_tlast[gidx];
  assign axis.axis_o_tdata  = axis.axis_i_tdata[gidx*DW +: DW];
  assign axis.axis_o_tuser  = axis.axis_i_tuser[gidx*UW +: UW];
  assign axis.axis_o_drop   = axis.axis_o_tvalid
                            & axis.axis_i_error[gidx];
  assign axis.axis_i_tready = o_grant
                            & {NUM_PORTS{axis.axis_o_tready}};

  assign last_hs = axis.axis_o_tvalid
                 & axis.axis_o_tready
                 & axis.axis_o_tlast;

  assign ptr_nxt = (gidx == IW'(NUM_PORTS - 1)) ? '0
                 : gidx + 1'b1;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      ptr         <= '0;
      gidx        <= '0;
      o_grant     <= '0;
      o_pkt_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            state   <= PASS;
            o_grant <= sel_gnt;
            gidx    <= sel_idx;
          end
        end
        PASS: begin
          if (last_hs) begin
            state   <= IDLE;
            o_grant <= '0;
            ptr     <= ptr_nxt;
            if (o_pkt_count != PKT_CNT_MAX)
              o_pkt_count <= o_pkt_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter.
// Per-port source queues drive beats; a monitor checks output beats.
module tb_axis_packet_arbiter;
  import axis_arb_pkg::*;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int UW = 1;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [NP-1:0] o_grant;
  logic [15:0] o_pkt_count;

  axis_packet_arbiter_if #(
    .NUM_PORTS(NP),
    .AXIS_BYTES(1),
    .AXIS_USER_BITS(UW)
  ) bus ();

  axis_packet_arbiter #(
    .AXIS_BYTES(1),
    .AXIS_USER_BITS(UW),
    .NUM_PORTS(NP)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .axis        (bus),
    .o_grant     (o_grant),
    .o_pkt_count (o_pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       bub;
    logic [7:0] data;
    logic       last;
    logic       err;
    logic       user;
  } beat_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
    logic       drop;
    logic       user;
  } exp_t;

  beat_t src [NP][$];
  exp_t  sb [$];
  logic  rdy_pat [$];
  int    hs_log [$];
  bit    log_en = 1'b0;
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  logic [NP-1:0] hs;
  logic [NP-1:0] bub_now;
  beat_t drv_b;
  exp_t  mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  function automatic bit src_busy();
    for (int p = 0; p < NP; p++)
      if (src[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load(input int p, input int n,
                      input int err_beat, input bit gaps);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.bub  = 1'b0;
      b.data = 8'(p * 16 + k);
      b.last = (k == n - 1);
      b.err  = (k == err_beat);
      b.user = 1'(k & 1);
      src[p].push_back(b);
      if (gaps && k < n - 1) begin
        b.bub = 1'b1;
        src[p].push_back(b);
      end
    end
  endtask

  task automatic expect_pkt(input int p, input int n,
                            input int err_beat, input int k_max);
    exp_t e;
    for (int k = 0; k < k_max; k++) begin
      e.port = p;
      e.data = 8'(p * 16 + k);
      e.last = (k == n - 1);
      e.drop = (k == err_beat);
      e.user = 1'(k & 1);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name, input int limit);
    int k;
    k = 0;
    while ((sb.size() != 0 || src_busy()) && k < limit) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check(name, 32'(k < limit), 32'd1);
  endtask

  // Source driver: pops beats on handshake, bubbles after one cycle.
  initial begin
    bus.axis_i_tvalid = '0;
    bus.axis_i_tlast  = '0;
    bus.axis_i_error  = '0;
    bus.axis_i_tdata  = '0;
    bus.axis_i_tuser  = '0;
    bus.axis_o_tready = 1'b1;
    bub_now = '0;
    forever begin
      @(negedge clk);
      hs = bus.axis_i_tvalid & bus.axis_i_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (aresetn && (bub_now[p] || hs[p]) && src[p].size() != 0)
          void'(src[p].pop_front());
        bub_now[p] = 1'b0;
        bus.axis_i_tvalid[p] = 1'b0;
        if (src[p].size() != 0) begin
          drv_b = src[p][0];
          bub_now[p] = drv_b.bub;
          bus.axis_i_tvalid[p] = !drv_b.bub;
          bus.axis_i_tlast[p]  = drv_b.last;
          bus.axis_i_error[p]  = drv_b.err;
          bus.axis_i_tdata[p*DW +: DW] = drv_b.data;
          bus.axis_i_tuser[p*UW +: UW] = drv_b.user;
        end
      end
      if (rdy_pat.size() != 0) bus.axis_o_tready = rdy_pat.pop_front();
      else bus.axis_o_tready = 1'b1;
    end
  end

  // Monitor: every output handshake must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (aresetn && bus.axis_o_tvalid && bus.axis_o_tready) begin
        if (log_en) hs_log.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h want none",
                   bus.axis_o_tdata);
        end else begin
          mon_e = sb.pop_front();
          check("beat",
                32'({bus.axis_o_tdata, bus.axis_o_tlast,
                     bus.axis_o_drop, bus.axis_o_tuser}),
                32'({mon_e.data, mon_e.last, mon_e.drop, mon_e.user}));
          check("grant_ready",
                32'({o_grant, bus.axis_i_tready}),
                32'({4'(1 << mon_e.port), 4'(1 << mon_e.port)}));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_count", 32'(o_pkt_count), 32'd0);
    check("rst_outs",
          32'({bus.axis_i_tready, bus.axis_o_tvalid, bus.axis_o_drop}),
          32'd0);
    aresetn = 1'b1;

    // All four ports at once: strict 0,1,2,3 order.
    log_en = 1'b1;
    for (int p = 0; p < NP; p++) load(p, 3, -1, 1'b0);
    for (int p = 0; p < NP; p++) expect_pkt(p, 3, -1, 3);
    drain("s1_drain", 200);
    log_en = 1'b0;
    check("s1_count", 32'(o_pkt_count), 32'd4);
    check("s1_beats", 32'(hs_log.size()), 32'd12);
    for (int i = 1; i < hs_log.size(); i++)
      check("s1_gap", 32'(hs_log[i] - hs_log[i-1]),
            (i % 3 == 0) ? 32'd2 : 32'd1);

    // Port 1 alone, then 0 and 2 together: pointer favours 2.
    load(1, 2, -1, 1'b0);
    expect_pkt(1, 2, -1, 2);
    drain("s2a_drain", 100);
    load(0, 2, -1, 1'b0);
    load(2, 2, -1, 1'b0);
    expect_pkt(2, 2, -1, 2);
    expect_pkt(0, 2, -1, 2);
    drain("s2b_drain", 100);
    check("s2_count", 32'(o_pkt_count), 32'd7);

    // Error on beat 2 of 4 from port 3.
    load(3, 4, 1, 1'b0);
    expect_pkt(3, 4, 1, 4);
    drain("s3_drain", 100);
    check("s3_count", 32'(o_pkt_count), 32'd8);

    // Output backpressure plus source gaps.
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    load(0, 3, -1, 1'b1);
    expect_pkt(0, 3, -1, 3);
    drain("s4_drain", 100);
    check("s4_count", 32'(o_pkt_count), 32'd9);

    // Reset mid-packet after two beats of port 2.
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0};
    load(2, 4, -1, 1'b0);
    expect_pkt(2, 4, -1, 2);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    check("s5_pre", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    check("s5_mid_grant", 32'(o_grant), 32'b0100);
    #1 aresetn = 1'b0;
    #1;
    check("s5_rst_grant", 32'(o_grant), 32'd0);
    check("s5_rst_count", 32'(o_pkt_count), 32'd0);
    check("s5_rst_outs",
          32'({bus.axis_i_tready, bus.axis_o_tvalid, bus.axis_o_drop}),
          32'd0);
    for (int p = 0; p < NP; p++) src[p].delete();
    rdy_pat.delete();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    load(2, 1, -1, 1'b0);
    load(0, 2, -1, 1'b0);
    expect_pkt(0, 2, -1, 2);
    expect_pkt(2, 1, -1, 1);
    drain("s5_drain", 100);
    check("s5_count", 32'(o_pkt_count), 32'd2);

    // Saturation: 65540 single-beat packets on top of the 2 above.
    for (int i = 0; i < 100; i++) begin
      load(0, 1, -1, 1'b0);
      expect_pkt(0, 1, -1, 1);
    end
    drain("s6a_drain", 400);
    check("s6_mid_count", 32'(o_pkt_count), 32'd102);
    for (int i = 0; i < 65440; i++) begin
      load(0, 1, -1, 1'b0);
      expect_pkt(0, 1, -1, 1);
    end
    drain("s6b_drain", 140000);
    check("s6_sat_count", 32'(o_pkt_count), 32'hFFFF);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
